// File: rtl/pipe_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the CPU pipeline stage
//                registers: occupancy type and encodings, the NOP instruction
//                used as the idle payload, and a small occupancy helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    // addi x0, x0, 0 -- idle payload for instruction-carrying stages
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Number of held entries given the two valid bits
    function automatic occ_t occ_count(input logic head_valid, input logic skid_valid);
        occ_t occ;
        occ = OCC_EMPTY;
        if (head_valid && skid_valid) begin
            occ = OCC_FULL;
        end else if (head_valid || skid_valid) begin
            occ = OCC_ONE;
        end
        return occ;
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_data_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pipe_data_reg
//  Description : Payload register with asynchronous active-low reset, a
//                synchronous clear (wins over load) and a load enable.
//  Ports       : clk, n_rst       clock / async active-low reset
//                i_load           capture i_d on the next edge
//                i_clr            return to RESET_VALUE on the next edge
//                i_d / o_q        payload in / out
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_data_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_q <= RESET_VALUE;
        end else if (i_clr) begin
            r_q <= RESET_VALUE;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_data_reg
`default_nettype wire

// File: rtl/pipe_elastic_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pipe_elastic_stage
//  Description : Valid/ready pipeline register between CPU stages. With
//                SKID_EN=1 a second (skid) entry lets i_in_ready come straight
//                from a flop; with SKID_EN=0 it is a single entry with a
//                combinational ready. Synchronous flush kills held entries; a
//                saturating counter tracks stalled output cycles.
//  Ports       : clk, n_rst                 clock / async active-low reset
//                i_flush                    kill all held entries
//                i_clr_stats                clear o_stall_cnt
//                i_in_valid/o_in_ready/i_in_data      upstream handshake
//                o_out_valid/i_out_ready/o_out_data   downstream handshake
//                o_occupancy                held entries (0..2)
//                o_stall_cnt                cycles with out_valid & !out_ready
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_elastic_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SKID_EN     = 1'b1,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_flush,
    input  logic             i_clr_stats,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [1:0]       o_occupancy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             r_head_valid;
    logic             w_skid_valid;
    logic             w_in_ready;
    logic             w_acc;
    logic             w_pop;
    logic             w_head_load;
    logic             w_head_from_skid;
    logic             w_skid_load;
    logic             w_head_valid_nxt;
    logic             w_skid_valid_nxt;
    logic [WIDTH-1:0] w_head_d;
    logic [WIDTH-1:0] w_head_q;
    logic [WIDTH-1:0] w_skid_q;
    logic [CNT_W-1:0] r_stall_cnt;

    // With a skid entry, ready depends only on the skid flop; otherwise the
    // single entry can accept whenever it is empty or draining this cycle.
    assign w_in_ready = SKID_EN ? !w_skid_valid : (!r_head_valid || i_out_ready);
    assign w_acc      = i_in_valid && w_in_ready;
    assign w_pop      = r_head_valid && i_out_ready;

    // Next-state / datapath steering for the two entries
    always_comb begin
        w_head_load      = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_head_valid_nxt = r_head_valid;
        w_skid_valid_nxt = w_skid_valid;
        if (w_pop && w_skid_valid) begin
            // Skid advances to head; a simultaneous accept refills skid
            w_head_load      = 1'b1;
            w_head_from_skid = 1'b1;
            w_head_valid_nxt = 1'b1;
            w_skid_load      = w_acc;
            w_skid_valid_nxt = w_acc;
        end else if (w_acc && (!r_head_valid || w_pop)) begin
            w_head_load      = 1'b1;
            w_head_valid_nxt = 1'b1;
        end else if (w_acc) begin
            // Head is held and not draining: only reachable with a skid entry
            w_skid_load      = 1'b1;
            w_skid_valid_nxt = 1'b1;
        end else if (w_pop) begin
            w_head_valid_nxt = 1'b0;
        end
    end

    assign w_head_d = w_head_from_skid ? w_skid_q : i_in_data;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_head_valid <= 1'b0;
        end else if (i_flush) begin
            r_head_valid <= 1'b0;
        end else begin
            r_head_valid <= w_head_valid_nxt;
        end
    end

    pipe_data_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_head_reg (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_load (w_head_load),
        .i_clr  (i_flush),
        .i_d    (w_head_d),
        .o_q    (w_head_q)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic r_skid_valid;

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_skid_valid <= 1'b0;
                end else if (i_flush) begin
                    r_skid_valid <= 1'b0;
                end else begin
                    r_skid_valid <= w_skid_valid_nxt;
                end
            end

            pipe_data_reg #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_skid_reg (
                .clk    (clk),
                .n_rst  (n_rst),
                .i_load (w_skid_load),
                .i_clr  (i_flush),
                .i_d    (i_in_data),
                .o_q    (w_skid_q)
            );

            assign w_skid_valid = r_skid_valid;
        end else begin : g_no_skid
            assign w_skid_valid = 1'b0;
            assign w_skid_q     = RESET_VALUE;
        end
    endgenerate

    // Stall counter: clear wins, saturates at all-ones, ignores flush
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stall_cnt <= '0;
        end else if (i_clr_stats) begin
            r_stall_cnt <= '0;
        end else if (r_head_valid && !i_out_ready && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_head_valid;
    assign o_out_data  = w_head_q;
    assign o_occupancy = occ_count(r_head_valid, w_skid_valid);
    assign o_stall_cnt = r_stall_cnt;

endmodule : pipe_elastic_stage
`default_nettype wire
